// File: rtl/seq_divider32_pkg.sv
// Shared ALU package: divider state encoding, default width and counter sizing.
package seq_divider32_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // FIX is only reachable when the signed build option is enabled.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  // Iteration counter width: enough to hold WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_divider32_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module seq_divider32_step
  import seq_divider32_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The shifted partial remainder can reach 2*divisor-1, so it keeps one extra
  // bit; the trial difference gets a second extra bit whose MSB is the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // Trial subtract and restore-or-keep selection.
  always_comb begin
    shifted  = {rem, quo_msb};
    trial    = {1'b0, shifted} - {2'b00, divisor};
    borrow   = trial[WIDTH+1];
    q_bit    = ~borrow;
    rem_next = borrow ? WIDTH'(shifted) : WIDTH'(trial);
  end

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Optional signed mode: define SEQ_DIVIDER_SIGNED_EN (adds signed_op port and FIX state).
module seq_divider32
  import seq_divider32_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  div_state_e       state, state_next;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt;

  logic             accept, load_op, load_zero, last_iter;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic             q_bit;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             q_neg, r_neg;
  logic             a_neg, b_neg;

  // Signed operands are iterated as magnitudes; the most-negative value maps to 2^(WIDTH-1).
  always_comb begin
    a_neg = signed_op & dividend[WIDTH-1];
    b_neg = signed_op & divisor[WIDTH-1];
    op_a  = a_neg ? (~dividend + WIDTH'(1)) : dividend;
    op_b  = b_neg ? (~divisor + WIDTH'(1)) : divisor;
  end
`else
  assign op_a = dividend;
  assign op_b = divisor;
`endif

  seq_divider32_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo_msb  (quo_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_next = {quo_q[WIDTH-2:0], q_bit};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (divisor == '0) ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (cnt == LAST) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_next = FIX;
`else
          state_next = DONE;
`endif
        end
      end
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    accept    = 1'b0;
    load_op   = 1'b0;
    load_zero = 1'b0;
    last_iter = 1'b0;
    if ((state == IDLE) || (state == DONE)) accept = start;
    load_op   = accept & (divisor != '0);
    load_zero = accept & (divisor == '0);
    last_iter = (state == RUN) && (cnt == LAST);
  end

  // Datapath, iteration counter and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      busy <= (state_next == RUN) || (state_next == FIX);
      done <= (state_next == DONE);

      if (load_op) begin
        rem_q       <= '0;
        quo_q       <= op_a;
        dvs_q       <= op_b;
        cnt         <= '0;
        div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg       <= a_neg ^ b_neg;
        r_neg       <= a_neg;
`endif
      end

      if (load_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end

      if (state == RUN) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        cnt   <= cnt + CW'(1);
`ifndef SEQ_DIVIDER_SIGNED_EN
        if (last_iter) begin
          quotient  <= quo_next;
          remainder <= rem_next;
        end
`endif
      end

`ifdef SEQ_DIVIDER_SIGNED_EN
      // Apply result signs after the magnitude iterations complete.
      if (state == FIX) begin
        quotient  <= q_neg ? (~quo_q + WIDTH'(1)) : quo_q;
        remainder <= r_neg ? (~rem_q + WIDTH'(1)) : rem_q;
      end
`endif
    end
  end

endmodule
